// File: rtl/touch_filter_pkg.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : touch_filter_pkg
// Purpose  : Shared widths, LCD geometry, calibration defaults and FSM states
//            for the touch_filter block.
// Revision : 1.0 - initial release
// ============================================================================
package touch_filter_pkg;

    localparam int c_raw_w  = 12;   // touchScreen controller sample width
    localparam int c_frac_w = 12;   // Q0.12 calibration multipliers
    localparam int c_x_w    = 10;   // matches h_count
    localparam int c_y_w    = 9;    // matches v_count

    localparam int c_h_res  = 480;
    localparam int c_v_res  = 272;

    localparam int c_z_thresh = 200;
    localparam int c_x_min    = 200;
    localparam int c_y_min    = 200;
    localparam int c_x_scale  = 1500;
    localparam int c_y_scale  = 900;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_ACCUM    = 2'd2,
        ST_SCALE    = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/touch_axis_scale.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : touch_axis_scale
// Purpose  : Combinational average / offset / Q0.12 multiply / clamp that
//            maps one accumulated raw axis onto LCD pixel space.
// Revision : 1.0 - initial release
// ============================================================================
module touch_axis_scale
    import touch_filter_pkg::*;
#(
    parameter int AVG_LOG2 = 2,
    parameter int MIN      = 200,
    parameter int SCALE    = 1500,
    parameter int RES      = 480,
    parameter int OUT_W    = 10
) (
    input  logic [c_raw_w+AVG_LOG2-1:0] i_acc,
    output logic [OUT_W-1:0]            o_pos
);

    localparam int c_acc_w  = c_raw_w + AVG_LOG2;
    localparam int c_prod_w = c_acc_w + c_frac_w;

    logic [c_acc_w-1:0]  w_avg;
    logic [c_acc_w-1:0]  w_delta;
    logic [c_prod_w-1:0] w_prod;
    logic [c_prod_w-1:0] w_pix;

    // Full-width arithmetic throughout; the average never exceeds 12 bits so
    // the product fits the 24-bit Q0.12 result with headroom to spare.
    always_comb begin
        w_avg   = i_acc >> AVG_LOG2;
        w_delta = (w_avg >= c_acc_w'(MIN)) ? (w_avg - c_acc_w'(MIN)) : '0;
        w_prod  = c_prod_w'(w_delta) * c_prod_w'(SCALE);
        w_pix   = w_prod >> c_frac_w;
        o_pos   = (w_pix > c_prod_w'(RES - 1)) ? OUT_W'(RES - 1) : OUT_W'(w_pix);
    end

endmodule
`default_nettype wire

// File: rtl/touch_filter.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : touch_filter
// Purpose  : Samples raw touch X/Y/Z, debounces pen contact, averages samples
//            and delivers pixel coordinates plus valid/release pulses.
// Revision : 1.0 - initial release
// ============================================================================
module touch_filter
    import touch_filter_pkg::*;
#(
    parameter int SAMPLE_DIV  = 75000,
    parameter int AVG_LOG2    = 2,
    parameter int DEBOUNCE    = 3,
    parameter int RELEASE_CNT = 3,
    parameter int Z_THRESH    = c_z_thresh,
    parameter int X_MIN       = c_x_min,
    parameter int Y_MIN       = c_y_min,
    parameter int X_SCALE     = c_x_scale,
    parameter int Y_SCALE     = c_y_scale,
    parameter int H_RES       = c_h_res,
    parameter int V_RES       = c_v_res
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [c_raw_w-1:0] x_raw,
    input  logic [c_raw_w-1:0] y_raw,
    input  logic [c_raw_w-1:0] z_raw,
    output logic [c_x_w-1:0]   x_pos,
    output logic [c_y_w-1:0]   y_pos,
    output logic               touch_valid,
    output logic               pen_down,
    output logic               release_pulse   // "release" is a reserved word
);

    localparam int c_tick_w = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int c_acc_w  = c_raw_w + AVG_LOG2;
    localparam int c_n_w    = AVG_LOG2 + 1;
    localparam int c_dbc_w  = $clog2(DEBOUNCE + 1);
    localparam int c_up_w   = $clog2(RELEASE_CNT + 1);
    localparam logic [c_n_w-1:0] c_n_full = c_n_w'(1 << AVG_LOG2);

    state_t              r_state;
    logic [c_tick_w-1:0] r_tick_cnt;
    logic [c_dbc_w-1:0]  r_dbc;
    logic [c_up_w-1:0]   r_up_cnt;
    logic [c_n_w-1:0]    r_n;
    logic [c_acc_w-1:0]  r_acc_x;
    logic [c_acc_w-1:0]  r_acc_y;
    logic [c_x_w-1:0]    r_x_pos;
    logic [c_y_w-1:0]    r_y_pos;
    logic                r_touch_valid;
    logic                r_pen_down;
    logic                r_release;

    logic                w_tick;
    logic                w_pressed;
    logic [c_x_w-1:0]    w_x_scaled;
    logic [c_y_w-1:0]    w_y_scaled;

    assign w_tick    = (r_tick_cnt == c_tick_w'(SAMPLE_DIV - 1));
    assign w_pressed = (z_raw >= c_raw_w'(Z_THRESH));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + c_tick_w'(1);
        end
    end

    touch_axis_scale #(
        .AVG_LOG2 (AVG_LOG2),
        .MIN      (X_MIN),
        .SCALE    (X_SCALE),
        .RES      (H_RES),
        .OUT_W    (c_x_w)
    ) u_x_scale (
        .i_acc    (r_acc_x),
        .o_pos    (w_x_scaled)
    );

    touch_axis_scale #(
        .AVG_LOG2 (AVG_LOG2),
        .MIN      (Y_MIN),
        .SCALE    (Y_SCALE),
        .RES      (V_RES),
        .OUT_W    (c_y_w)
    ) u_y_scale (
        .i_acc    (r_acc_y),
        .o_pos    (w_y_scaled)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_dbc         <= '0;
            r_up_cnt      <= '0;
            r_n           <= '0;
            r_acc_x       <= '0;
            r_acc_y       <= '0;
            r_x_pos       <= '0;
            r_y_pos       <= '0;
            r_touch_valid <= 1'b0;
            r_pen_down    <= 1'b0;
            r_release     <= 1'b0;
        end else begin
            r_touch_valid <= 1'b0;
            r_release     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_tick && w_pressed) begin
                        if (DEBOUNCE <= 1) begin
                            r_state    <= ST_ACCUM;
                            r_pen_down <= 1'b1;
                            r_dbc      <= '0;
                            r_up_cnt   <= '0;
                            r_n        <= '0;
                            r_acc_x    <= '0;
                            r_acc_y    <= '0;
                        end else begin
                            r_dbc   <= c_dbc_w'(1);
                            r_state <= ST_DEBOUNCE;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (w_tick) begin
                        if (!w_pressed) begin
                            r_dbc   <= '0;
                            r_state <= ST_IDLE;
                        end else if (r_dbc + c_dbc_w'(1) == c_dbc_w'(DEBOUNCE)) begin
                            r_state    <= ST_ACCUM;
                            r_pen_down <= 1'b1;
                            r_dbc      <= '0;
                            r_up_cnt   <= '0;
                            r_n        <= '0;
                            r_acc_x    <= '0;
                            r_acc_y    <= '0;
                        end else begin
                            r_dbc <= r_dbc + c_dbc_w'(1);
                        end
                    end
                end
                ST_ACCUM: begin
                    if (w_tick) begin
                        if (w_pressed) begin
                            r_acc_x  <= r_acc_x + c_acc_w'(x_raw);
                            r_acc_y  <= r_acc_y + c_acc_w'(y_raw);
                            r_n      <= r_n + c_n_w'(1);
                            r_up_cnt <= '0;
                            if (r_n + c_n_w'(1) == c_n_full) begin
                                r_state <= ST_SCALE;
                            end
                        end else if (r_up_cnt + c_up_w'(1) == c_up_w'(RELEASE_CNT)) begin
                            // Lift-off: drop any partial average, keep last point.
                            r_state    <= ST_IDLE;
                            r_release  <= 1'b1;
                            r_pen_down <= 1'b0;
                            r_up_cnt   <= '0;
                            r_n        <= '0;
                            r_acc_x    <= '0;
                            r_acc_y    <= '0;
                        end else begin
                            r_up_cnt <= r_up_cnt + c_up_w'(1);
                        end
                    end
                end
                ST_SCALE: begin
                    // Any tick landing here is intentionally ignored.
                    r_x_pos       <= w_x_scaled;
                    r_y_pos       <= w_y_scaled;
                    r_touch_valid <= 1'b1;
                    r_n           <= '0;
                    r_acc_x       <= '0;
                    r_acc_y       <= '0;
                    r_state       <= ST_ACCUM;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign x_pos         = r_x_pos;
    assign y_pos         = r_y_pos;
    assign touch_valid   = r_touch_valid;
    assign pen_down      = r_pen_down;
    assign release_pulse = r_release;

endmodule
`default_nettype wire

// File: tb/tb_touch_filter.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : tb_touch_filter
// Purpose  : Self-checking bench for touch_filter: tick-level reference model,
//            directed corner sequences, vector table and random strokes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_touch_filter;

    localparam int c_sample_div  = 8;
    localparam int c_avg_log2    = 2;
    localparam int c_debounce    = 3;
    localparam int c_release_cnt = 3;
    localparam int c_z_thresh    = 200;
    localparam int c_x_min       = 200;
    localparam int c_y_min       = 200;
    localparam int c_x_scale     = 1500;
    localparam int c_y_scale     = 900;
    localparam int c_h_res       = 480;
    localparam int c_v_res       = 272;
    localparam int c_n_avg       = 1 << c_avg_log2;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic [11:0] x_raw = '0;
    logic [11:0] y_raw = '0;
    logic [11:0] z_raw = '0;
    logic [9:0]  x_pos;
    logic [8:0]  y_pos;
    logic        touch_valid;
    logic        pen_down;
    logic        release_pulse;

    always #5 clk = ~clk;

    touch_filter #(
        .SAMPLE_DIV  (c_sample_div),
        .AVG_LOG2    (c_avg_log2),
        .DEBOUNCE    (c_debounce),
        .RELEASE_CNT (c_release_cnt),
        .Z_THRESH    (c_z_thresh),
        .X_MIN       (c_x_min),
        .Y_MIN       (c_y_min),
        .X_SCALE     (c_x_scale),
        .Y_SCALE     (c_y_scale),
        .H_RES       (c_h_res),
        .V_RES       (c_v_res)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .x_raw         (x_raw),
        .y_raw         (y_raw),
        .z_raw         (z_raw),
        .x_pos         (x_pos),
        .y_pos         (y_pos),
        .touch_valid   (touch_valid),
        .pen_down      (pen_down),
        .release_pulse (release_pulse)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: pen behaviour described in ticks and a sample queue.
    int  m_edge, m_presses, m_misses, m_x, m_y;
    bit  m_down, m_scale_due, m_tv, m_rel, m_last_tick;
    int  q_x[$];
    int  q_y[$];
    int  tv_seen, rel_seen, pd_seen;

    typedef struct {
        logic [11:0] x;
        logic [11:0] y;
        logic [11:0] z;
        int          exp_x;
        int          exp_y;
    } vec_t;
    vec_t vecs[6];

    function automatic int to_px(int sum, int mn, int sc, int res);
        int avg, d, p;
        avg = sum / c_n_avg;
        d   = (avg > mn) ? avg - mn : 0;
        p   = (d * sc) / 4096;
        return (p > res - 1) ? res - 1 : p;
    endfunction

    task automatic model_reset();
        m_edge = 0; m_presses = 0; m_misses = 0; m_x = 0; m_y = 0;
        m_down = 0; m_scale_due = 0; m_tv = 0; m_rel = 0; m_last_tick = 0;
        q_x.delete(); q_y.delete();
    endtask

    task automatic model_edge();
        bit t, pr;
        int sx, sy;
        m_edge++;
        t  = ((m_edge % c_sample_div) == 0);
        pr = (int'(z_raw) >= c_z_thresh);
        m_tv = 0; m_rel = 0;
        if (m_scale_due) begin
            sx = 0; sy = 0;
            foreach (q_x[i]) begin sx += q_x[i]; sy += q_y[i]; end
            m_x = to_px(sx, c_x_min, c_x_scale, c_h_res);
            m_y = to_px(sy, c_y_min, c_y_scale, c_v_res);
            m_tv = 1; m_scale_due = 0;
            q_x.delete(); q_y.delete();
        end else if (t && !m_down) begin
            if (pr) begin
                m_presses++;
                if (m_presses == c_debounce) begin
                    m_down = 1; m_presses = 0; m_misses = 0;
                    q_x.delete(); q_y.delete();
                end
            end else begin
                m_presses = 0;
            end
        end else if (t && pr) begin
            q_x.push_back(int'(x_raw)); q_y.push_back(int'(y_raw));
            m_misses = 0;
            if (q_x.size() == c_n_avg) m_scale_due = 1;
        end else if (t) begin
            m_misses++;
            if (m_misses == c_release_cnt) begin
                m_down = 0; m_rel = 1; m_misses = 0;
                q_x.delete(); q_y.delete();
            end
        end
        m_last_tick = t;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        checks++;
        if (touch_valid === 1'b1) tv_seen++;
        if (release_pulse === 1'b1) rel_seen++;
        if (pen_down === 1'b1) pd_seen++;
        if (pen_down !== m_down || touch_valid !== m_tv || release_pulse !== m_rel ||
            x_pos !== 10'(m_x) || y_pos !== 9'(m_y)) begin
            errors++;
            $display("FAIL cycle@%0t: pd=%b tv=%b rel=%b x=%0d y=%0d expected pd=%b tv=%b rel=%b x=%0d y=%0d",
                     $time, pen_down, touch_valid, release_pulse, x_pos, y_pos,
                     m_down, m_tv, m_rel, m_x, m_y);
        end
    endtask

    task automatic wait_tick();
        int k;
        k = 0;
        do begin step(); k++; end while (!m_last_tick && k < 2 * c_sample_div);
        if (!m_last_tick) begin
            checks++; errors++;
            $display("FAIL wait_tick: no tick within %0d cycles", k);
        end
    endtask

    task automatic apply_reset(input int n);
        reset = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        check("reset_hold_zero", {pen_down, touch_valid, release_pulse, x_pos, y_pos}, 0);
        reset = 1'b1;
        model_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pd_edge, tv_edge, rel0, tv0, pd0, len;
        bit got;

        vecs[0] = '{x: 12'd1000, y: 12'd1000, z: 12'd500, exp_x: 292, exp_y: 175};
        vecs[1] = '{x: 12'd100,  y: 12'd100,  z: 12'd500, exp_x: 0,   exp_y: 0};
        vecs[2] = '{x: 12'd4095, y: 12'd4095, z: 12'd500, exp_x: 479, exp_y: 271};
        vecs[3] = '{x: 12'd1510, y: 12'd1400, z: 12'd500, exp_x: 479, exp_y: 263};
        vecs[4] = '{x: 12'd200,  y: 12'd200,  z: 12'd4095, exp_x: 0,  exp_y: 0};
        vecs[5] = '{x: 12'd1500, y: 12'd500,  z: 12'd200, exp_x: 476, exp_y: 65};
        model_reset();
        tv_seen = 0; rel_seen = 0; pd_seen = 0;

        // Reset held low with active inputs, then first stroke timing.
        reset = 1'b0; z_raw = 12'd500; x_raw = 12'd1000; y_raw = 12'd1000;
        repeat (3) begin
            @(posedge clk); #1;
            check("reset_outputs", {pen_down, touch_valid, release_pulse, x_pos, y_pos}, 0);
        end
        reset = 1'b1;
        model_reset();
        pd_edge = 0; tv_edge = 0;
        for (int n = 1; n <= 100 && tv_edge == 0; n++) begin
            step();
            if (pen_down === 1'b1 && pd_edge == 0) pd_edge = n;
            if (touch_valid === 1'b1) tv_edge = n;
        end
        check("pen_down_edge", pd_edge, 24);
        check("valid_edge", tv_edge, 57);
        check("first_x", x_pos, 292);
        check("first_y", y_pos, 175);

        // Averaging of varying samples.
        tv0 = tv_seen;
        for (int i = 0; i < 4; i++) begin
            x_raw = 12'(1000 + 4 * i);
            wait_tick();
        end
        for (int k = 0; k < 4 && tv_seen == tv0; k++) step();
        check("avg_x", x_pos, 295);
        check("avg_y", y_pos, 175);

        // Lift-off during accumulation.
        rel0 = rel_seen;
        z_raw = 12'd50;
        repeat (c_release_cnt) wait_tick();
        repeat (4) step();
        check("release_count", rel_seen - rel0, 1);
        check("pen_down_after_release", pen_down, 0);
        check("x_hold_after_release", x_pos, 295);
        check("y_hold_after_release", y_pos, 175);

        // Short press that never qualifies.
        rel0 = rel_seen; tv0 = tv_seen; pd0 = pd_seen;
        z_raw = 12'd500;
        repeat (2) wait_tick();
        z_raw = 12'd50;
        repeat (3) wait_tick();
        check("short_pen_down", pd_seen - pd0, 0);
        check("short_valid", tv_seen - tv0, 0);
        check("short_release", rel_seen - rel0, 0);

        // Asynchronous reset in the middle of accumulation.
        z_raw = 12'd500;
        repeat (c_debounce + 2) wait_tick();
        check("pd_before_reset", pen_down, 1);
        #3 reset = 1'b0;
        #1 check("reset_mid_zero", {pen_down, touch_valid, release_pulse, x_pos, y_pos}, 0);
        repeat (2) begin
            @(posedge clk); #1;
            check("reset_mid_no_release", release_pulse, 0);
        end
        reset = 1'b1;
        model_reset();

        // Vector table: one full stroke per record.
        for (int i = 0; i < 6; i++) begin
            apply_reset(2);
            x_raw = vecs[i].x; y_raw = vecs[i].y; z_raw = vecs[i].z;
            got = 0;
            for (int k = 0; k < 200 && !got; k++) begin
                step();
                if (touch_valid === 1'b1) got = 1;
            end
            check($sformatf("table%0d_valid", i), got, 1);
            check($sformatf("table%0d_x", i), x_pos, vecs[i].exp_x);
            check($sformatf("table%0d_y", i), y_pos, vecs[i].exp_y);
        end

        // Random strokes checked cycle by cycle against the model.
        apply_reset(2);
        for (int seg = 0; seg < 160; seg++) begin
            case ($urandom_range(0, 5))
                0:       z_raw = 12'($urandom_range(0, 198));
                1:       z_raw = 12'd199;
                2:       z_raw = 12'd200;
                default: z_raw = 12'($urandom_range(200, 4095));
            endcase
            x_raw = 12'($urandom_range(0, 4095));
            y_raw = 12'($urandom_range(0, 4095));
            len = $urandom_range(4, 60);
            repeat (len) begin
                if ($urandom_range(0, 7) == 0) x_raw = 12'($urandom_range(0, 4095));
                step();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
